// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and default configuration for the FIFO write-port arbiter.
// Widths GW/CW follow the default requester count and burst length.
package fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int NREQ_DFLT      = 4;
  localparam int DW_DFLT        = 8;
  localparam int MAX_BURST_DFLT = 4;

  localparam int GW = $clog2(NREQ_DFLT);
  localparam int CW = $clog2(MAX_BURST_DFLT + 1);

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side handshake plus FIFO write port; slave is the arbiter's view.
interface fifo_wr_arbiter_if
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DFLT,
  parameter int DW   = DW_DFLT
);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_last;
  logic [NREQ-1:0]    req_ready;
  logic               full_flag;
  logic               w_enbl;
  logic [DW-1:0]      w_data;
  logic [GW-1:0]      grant_id;
  logic               busy;

  modport master (
    output req_valid, req_data, req_last, full_flag,
    input  req_ready, w_enbl, w_data, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, full_flag,
    output req_ready, w_enbl, w_data, grant_id, busy
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_priority_picker.sv
// Round-robin picker: first set req bit searching upward from last+1, wrapping.
// Purely combinational; no backpressure of its own.
module rr_priority_picker
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DFLT
) (
  input  logic [NREQ-1:0] req,
  input  logic [GW-1:0]   last,
  output logic [GW-1:0]   winner,
  output logic            any
);

  logic          found;
  logic [GW-1:0] cand;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = GW'((int'(last) + k) % NREQ);
      if (!found && req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
    any = |req;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares the FIFO write port among NREQ requesters in atomic round-robin bursts.
// Grant 1 cycle after request; beats are combinational and stall on full_flag.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DFLT,
  parameter int DW        = DW_DFLT,
  parameter int MAX_BURST = MAX_BURST_DFLT
) (
  input  logic             w_clk,
  input  logic             w_resetn,
  fifo_wr_arbiter_if.slave bus
);

  // Counter and grant widths come from the package; reject configs they cannot hold.
  if (NREQ < 2 || MAX_BURST < 1 || GW != $clog2(NREQ) || CW != $clog2(MAX_BURST + 1))
  begin : g_cfg_chk
    $error("fifo_wr_arbiter: parameters inconsistent with fifo_wr_arb_pkg widths");
  end

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [GW-1:0] grant_id;
  logic [GW-1:0] rr_last;
  logic [GW-1:0] winner;
  logic [CW-1:0] beat_cnt;
  logic          any_req;
  logic          g_valid;
  logic          g_last;
  logic [DW-1:0] g_data;
  logic          xfer;
  logic          burst_end;

  rr_priority_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req    (bus.req_valid),
    .last   (rr_last),
    .winner (winner),
    .any    (any_req)
  );

  assign g_valid = bus.req_valid[grant_id];
  assign g_last  = bus.req_last[grant_id];
  assign g_data  = bus.req_data[grant_id*DW +: DW];

  assign xfer      = (state == BURST) && g_valid && !bus.full_flag;
  assign burst_end = xfer && (g_last || (beat_cnt == CW'(MAX_BURST - 1)));

  always_ff @(posedge w_clk or negedge w_resetn) begin
    if (!w_resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)   state_nxt = BURST;
      BURST:   if (burst_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready = '0;
    bus.w_enbl    = 1'b0;
    bus.w_data    = '0;
    bus.busy      = 1'b0;
    if (state == BURST) begin
      bus.req_ready[grant_id] = !bus.full_flag;
      bus.w_enbl              = xfer;
      bus.w_data              = g_data;
      bus.busy                = 1'b1;
    end
  end

  // rr_last starts at NREQ-1 so requester 0 has first priority after reset.
  always_ff @(posedge w_clk or negedge w_resetn) begin
    if (!w_resetn) begin
      grant_id <= '0;
      rr_last  <= GW'(NREQ - 1);
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      if (any_req) begin
        grant_id <= winner;
        rr_last  <= winner;
        beat_cnt <= '0;
      end
    end else if (xfer) begin
      beat_cnt <= beat_cnt + CW'(1);
    end
  end

  assign bus.grant_id = grant_id;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: reset, single burst, round robin, full stall,
// grantee valid gap and mid-burst reset.
module tb_fifo_wr_arbiter;

  logic w_clk;
  logic w_resetn;
  int   errors;
  int   checks;
  int   wr_cnt;

  fifo_wr_arbiter_if #(.NREQ(4), .DW(8)) bus ();

  fifo_wr_arbiter #(
    .NREQ      (4),
    .DW        (8),
    .MAX_BURST (4)
  ) dut (
    .w_clk    (w_clk),
    .w_resetn (w_resetn),
    .bus      (bus)
  );

  initial begin
    w_clk = 1'b0;
    forever #5 w_clk = ~w_clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outs(input string tag, input logic [3:0] rdy, input logic en,
                      input logic [7:0] dat, input logic [1:0] gid, input logic bsy);
    wr_cnt += int'(bus.w_enbl);
    chk({tag, ".ready"}, 32'(bus.req_ready), 32'(rdy));
    chk({tag, ".w_enbl"}, 32'(bus.w_enbl), 32'(en));
    chk({tag, ".w_data"}, 32'(bus.w_data), 32'(dat));
    chk({tag, ".grant_id"}, 32'(bus.grant_id), 32'(gid));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
  endtask

  task automatic set_in(input logic [3:0] v, input logic [3:0] l, input logic f);
    bus.req_valid = v;
    bus.req_last  = l;
    bus.full_flag = f;
  endtask

  task automatic do_reset();
    @(negedge w_clk);
    w_resetn = 1'b0;
    set_in(4'b0000, 4'b0000, 1'b0);
    #1 outs("reset", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge w_clk);
    w_resetn = 1'b1;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    wr_cnt   = 0;
    w_resetn = 1'b0;
    bus.req_data = 32'h44332211;
    set_in(4'b0000, 4'b0000, 1'b0);

    // Single request from requester 0, last on beat 3
    do_reset();
    @(negedge w_clk); set_in(4'b0001, 4'b0000, 1'b0);
    #1 outs("single.idle", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge w_clk); #1 outs("single.b1", 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1);
    @(negedge w_clk); #1 outs("single.b2", 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1);
    @(negedge w_clk); set_in(4'b0001, 4'b0001, 1'b0);
    #1 outs("single.b3", 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1);
    @(negedge w_clk); set_in(4'b0000, 4'b0000, 1'b0);
    #1 outs("single.gap", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge w_clk); #1 outs("single.stay", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);

    // All requesters held valid: grants 0,1,2,3,0, four beats each
    do_reset();
    @(negedge w_clk); set_in(4'b1111, 4'b0000, 1'b0);
    #1 outs("rr.idle0", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    for (int n = 0; n < 5; n++) begin
      int g;
      g = n % 4;
      for (int b = 0; b < 4; b++) begin
        @(negedge w_clk);
        #1 outs($sformatf("rr.g%0d.b%0d", n, b), 4'(1 << g), 1'b1,
                8'(8'h11 * (g + 1)), 2'(g), 1'b1);
      end
      @(negedge w_clk);
      #1 outs($sformatf("rr.gap%0d", n), 4'b0000, 1'b0, 8'h00, 2'(g), 1'b0);
    end

    // Full stall for 3 cycles during beat 2
    do_reset();
    wr_cnt = 0;
    @(negedge w_clk); set_in(4'b0001, 4'b0000, 1'b0); bus.req_data[7:0] = 8'h01;
    #1 outs("full.idle", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge w_clk); #1 outs("full.b1", 4'b0001, 1'b1, 8'h01, 2'd0, 1'b1);
    for (int s = 0; s < 3; s++) begin
      @(negedge w_clk); set_in(4'b0001, 4'b0000, 1'b1); bus.req_data[7:0] = 8'h02;
      #1 outs($sformatf("full.stall%0d", s), 4'b0000, 1'b0, 8'h02, 2'd0, 1'b1);
      chk($sformatf("full.stall%0d.beat_cnt", s), 32'(dut.beat_cnt), 32'd1);
    end
    @(negedge w_clk); set_in(4'b0001, 4'b0000, 1'b0);
    #1 outs("full.b2", 4'b0001, 1'b1, 8'h02, 2'd0, 1'b1);
    chk("full.b2.beat_cnt", 32'(dut.beat_cnt), 32'd1);
    @(negedge w_clk); bus.req_data[7:0] = 8'h03;
    #1 outs("full.b3", 4'b0001, 1'b1, 8'h03, 2'd0, 1'b1);
    @(negedge w_clk); bus.req_data[7:0] = 8'h04;
    #1 outs("full.b4", 4'b0001, 1'b1, 8'h04, 2'd0, 1'b1);
    @(negedge w_clk); set_in(4'b0000, 4'b0000, 1'b0);
    #1 outs("full.done", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    chk("full.writes", 32'(wr_cnt), 32'd4);

    // Requester 2 drops valid mid-burst while requester 1 waits
    bus.req_data = 32'h44332211;
    @(negedge w_clk); set_in(4'b0010, 4'b0010, 1'b0);
    #1 outs("gap.idle0", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge w_clk); #1 outs("gap.r1", 4'b0010, 1'b1, 8'h22, 2'd1, 1'b1);
    @(negedge w_clk); set_in(4'b0110, 4'b0000, 1'b0);
    #1 outs("gap.idle1", 4'b0000, 1'b0, 8'h00, 2'd1, 1'b0);
    @(negedge w_clk); #1 outs("gap.b1", 4'b0100, 1'b1, 8'h33, 2'd2, 1'b1);
    @(negedge w_clk); set_in(4'b0010, 4'b0000, 1'b0);
    #1 outs("gap.hold0", 4'b0100, 1'b0, 8'h33, 2'd2, 1'b1);
    @(negedge w_clk); #1 outs("gap.hold1", 4'b0100, 1'b0, 8'h33, 2'd2, 1'b1);
    @(negedge w_clk); set_in(4'b0110, 4'b0000, 1'b0);
    #1 outs("gap.b2", 4'b0100, 1'b1, 8'h33, 2'd2, 1'b1);
    @(negedge w_clk); set_in(4'b0110, 4'b0100, 1'b0);
    #1 outs("gap.b3", 4'b0100, 1'b1, 8'h33, 2'd2, 1'b1);
    @(negedge w_clk); set_in(4'b0110, 4'b0000, 1'b0);
    #1 outs("gap.idle2", 4'b0000, 1'b0, 8'h00, 2'd2, 1'b0);
    @(negedge w_clk); #1 outs("gap.r1b", 4'b0010, 1'b1, 8'h22, 2'd1, 1'b1);

    // Reset asserted after beat 1 of a requester-3 burst
    do_reset();
    @(negedge w_clk); set_in(4'b1000, 4'b0000, 1'b0);
    #1 outs("mrst.idle", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge w_clk); #1 outs("mrst.b1", 4'b1000, 1'b1, 8'h44, 2'd3, 1'b1);
    @(negedge w_clk); w_resetn = 1'b0;
    #1 outs("mrst.inrst", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge w_clk); w_resetn = 1'b1; set_in(4'b1001, 4'b0000, 1'b0);
    #1 outs("mrst.idle2", 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0);
    @(negedge w_clk); #1 outs("mrst.r0", 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter for the asynchronous FIFO write domain. It shares the FIFO's single write port (`w_enbl`/`w_data`) among `NREQ` requesters using atomic bursts, and stalls on the write-pointer block's registered `full_flag`. It sits in the `w_clk` domain directly upstream of the write-pointer block and the FIFO memory write port.

## Interface
- `NREQ`, 4: number of requesters; must be at least 2.
- `DW`, 8: data width.
- `MAX_BURST`, 4: maximum beats per grant; must be at least 1.
- `w_clk`  in  1  write-domain clock.
- `w_resetn`  in  1  reset, asynchronous, active-low.
- `req_valid`  in  NREQ  per-requester data valid.
- `req_data`  in  NREQ*DW  packed data; requester i occupies `[i*DW +: DW]`.
- `req_last`  in  NREQ  last beat of the requester's burst.
- `req_ready`  out  NREQ  per-requester accept; one-hot or zero.
- `full_flag`  in  1  registered FIFO-full from the write-pointer block.
- `w_enbl`  out  1  FIFO write strobe.
- `w_data`  out  DW  FIFO write data.
- `grant_id`  out  $clog2(NREQ)  current or last granted requester.
- `busy`  out  1  high while in BURST.

## Operation
- **FSM states:** IDLE and BURST.
  - IDLE → BURST when any `req_valid` bit is set.
  - BURST → IDLE on the burst-ending beat.
- **Arbitration (in IDLE):** the winner is the first set `req_valid` bit searching upward from `rr_last+1`, wrapping modulo `NREQ`.
  - At the IDLE→BURST edge: `grant_id` ← winner, `rr_last` ← winner, `beat_cnt` ← 0.
- **Beat handshake (in BURST), with g = `grant_id`:**
  - `req_ready[g]` = !`full_flag`; all other `req_ready` bits are 0.
  - `w_enbl` = `req_valid[g]` & `req_ready[g]`.
  - `w_data` = `req_data[g]` while in BURST, else 0.
  - A beat transfers exactly when `w_enbl` is 1.
- **Beat counting:** each transfer increments `beat_cnt`.
  - The burst ends on a transfer with `req_last[g]`=1, or on a transfer with `beat_cnt`==`MAX_BURST`-1.
  - `beat_cnt` width is $clog2(MAX_BURST+1); it never wraps.
- **Bursts are atomic:**
  - If `req_valid[g]` drops mid-burst, the grant is held and no beats transfer.
  - Requests from other requesters are ignored until the burst ends.
- **Full handling:**
  - `full_flag`=1 forces `w_enbl`=0 and all `req_ready`=0.
  - The FSM holds state, and `beat_cnt` holds its value.
  - Transfer resumes in the first cycle with `full_flag`=0.
- **Outputs in IDLE:** `w_enbl`=0 and `req_ready`=0 in every IDLE cycle.
- **`req_last` outside a transfer:** has no effect.
- **Reset, asynchronous:**
  - State → IDLE.
  - `rr_last` → `NREQ`-1, so requester 0 has first priority.
  - `grant_id` → 0 and `beat_cnt` → 0.
  - Outputs: `req_ready`=0, `w_enbl`=0, `w_data`=0, `busy`=0.
  - Reset mid-burst abandons the burst; the next grant is arbitrated fresh.

## Timing
- **Arbitration latency:** 1 cycle. A `req_valid` sampled at edge k gives `busy`=1 and first possible transfer in cycle k+1.
- **`req_ready`, `w_enbl`, `w_data`:** combinational from registered state, `req_valid`/`req_data` of the grantee, and `full_flag`. No registered datapath, so no write is issued after `full_flag` rises.
- **Between bursts:** one dead IDLE cycle follows every burst end. Peak throughput is `MAX_BURST`/(`MAX_BURST`+1).
- **Fairness:** a continuously requesting requester waits at most (`NREQ`-1) bursts.

## Structure
- **Package `fifo_wr_arb_pkg`:**
  - State enum: IDLE, BURST.
  - Localparams `GW` = $clog2(NREQ) and `CW` = $clog2(MAX_BURST+1).
- **Sub-module `rr_priority_picker`:** combinational; inputs `req[NREQ]` and `last[GW]`; outputs `winner[GW]` and `any`.
- **Top level:** FSM, `beat_cnt`, `grant_id`/`rr_last` registers, and the data mux.

## Test plan
- **Reset and single request:** reset, then `req_valid`=0001 with `req_last` on beat 3.
  - `busy` rises 1 cycle after request; 3 writes of `req_data[0]`; then `busy`=0 for 1 cycle.
- **All requesters busy, `MAX_BURST`=4:** `req_valid`=1111 held, `req_last`=0.
  - Grants in order 0,1,2,3,0, each exactly 4 writes, with one IDLE cycle between grants.
- **Full stall:** `full_flag`=1 for 3 cycles in the middle of beat 2 of a burst.
  - `w_enbl`=0 and `req_ready`=0 during the stall; `beat_cnt` stays at 1.
  - Burst completes with 4 total writes and no lost or duplicated data.
- **Grantee drops valid:** requester 2 drops `req_valid` for 2 cycles mid-burst while requester 1 is requesting.
  - No grant change, no writes during the gap; requester 1 is granted only after requester 2's burst ends.
- **Reset mid-burst:** `w_resetn` pulsed low after beat 1 of a requester-3 burst.
  - All outputs go to their reset values immediately.
  - With `req_valid`=1001 after reset, requester 0 wins first.
